// File: rtl/axis_packet_distributor.sv
// Round-robin AXI-Stream packet distributor: whole packets to enabled outputs, PKTS_PER_OUTPUT per turn.
// Define AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN to add per-output packet counters on pkt_count.
module axis_packet_distributor #(
    parameter int  AXIS_BYTES        = 1,
    parameter int  AXIS_USER_BITS    = 1,
    parameter int  NUM_SLAVE_STREAMS = 2,
    parameter int  PKTS_PER_OUTPUT   = 1,
    localparam int DEST_BITS         = (NUM_SLAVE_STREAMS == 1) ? 1 : $clog2(NUM_SLAVE_STREAMS)
) (
    input  logic                                            clk,
    input  logic                                            sresetn,
    input  logic                                            axis_i_tvalid,
    output logic                                            axis_i_tready,
    input  logic                                            axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]                         axis_i_tdata,
    input  logic [AXIS_BYTES-1:0]                           axis_i_tkeep,
    input  logic [AXIS_USER_BITS-1:0]                       axis_i_tuser,
    output logic [NUM_SLAVE_STREAMS-1:0]                    axis_o_tvalid,
    input  logic [NUM_SLAVE_STREAMS-1:0]                    axis_o_tready,
    output logic [NUM_SLAVE_STREAMS-1:0]                    axis_o_tlast,
    output logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0]       axis_o_tdata,
    output logic [NUM_SLAVE_STREAMS*AXIS_BYTES-1:0]         axis_o_tkeep,
    output logic [NUM_SLAVE_STREAMS*AXIS_USER_BITS-1:0]     axis_o_tuser,
    input  logic [NUM_SLAVE_STREAMS-1:0]                    en_mask,
    output logic [DEST_BITS-1:0]                            cur_dest,
    output logic                                            busy
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
    ,
    output logic [NUM_SLAVE_STREAMS*32-1:0]                 pkt_count
`endif
);

    localparam int N = NUM_SLAVE_STREAMS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t               state_r;
    logic [DEST_BITS-1:0] ptr_r;
    logic [DEST_BITS-1:0] dest_r;
    logic [7:0]           burst_cnt_r;

    logic [2*N-1:0]       en_dbl_s;
    logic [N-1:0]         en_rot_s;
    logic [DEST_BITS:0]   ofs_s;
    logic [DEST_BITS:0]   sum_s;
    logic                 sel_valid_s;
    logic [DEST_BITS-1:0] sel_s;
    logic [DEST_BITS-1:0] dest_s;
    logic [DEST_BITS-1:0] next_ptr_s;
    logic                 active_s;
    logic                 ready_s;
    logic                 hs_s;
    logic [7:0]           burst_eff_s;
    logic                 burst_last_s;

    // Rotating the doubled mask by ptr_r turns the wrap-around search into a lowest-set-bit search.
    assign en_dbl_s = {en_mask, en_mask} >> ptr_r;
    assign en_rot_s = en_dbl_s[N-1:0];

    // Selection: first enabled output at or after the pointer, wrapping modulo N.
    always_comb begin
        ofs_s       = '0;
        sel_valid_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en_rot_s[i]) begin
                ofs_s       = (DEST_BITS+1)'(i);
                sel_valid_s = 1'b1;
            end else begin
                ofs_s       = ofs_s;
            end
        end
        sum_s = {1'b0, ptr_r} + ofs_s;
        if (sum_s >= (DEST_BITS+1)'(N)) begin
            sel_s = DEST_BITS'(sum_s - (DEST_BITS+1)'(N));
        end else begin
            sel_s = sum_s[DEST_BITS-1:0];
        end
    end

    assign dest_s   = (state_r == ST_PKT) ? dest_r : sel_s;
    assign active_s = (state_r == ST_PKT) || sel_valid_s;

    // Steer valid to the chosen output and return that output's ready.
    always_comb begin
        axis_o_tvalid = '0;
        ready_s       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (active_s && (dest_s == DEST_BITS'(i))) begin
                axis_o_tvalid[i] = axis_i_tvalid;
                ready_s          = axis_o_tready[i];
            end else begin
                axis_o_tvalid[i] = 1'b0;
            end
        end
    end

    assign axis_i_tready = ready_s;
    assign hs_s          = axis_i_tvalid & ready_s;
    assign axis_o_tlast  = {N{axis_i_tlast}};
    assign axis_o_tdata  = {N{axis_i_tdata}};
    assign axis_o_tkeep  = {N{axis_i_tkeep}};
    assign axis_o_tuser  = {N{axis_i_tuser}};
    assign cur_dest      = dest_s;
    assign busy          = (state_r == ST_PKT);

    // A packet that starts anywhere other than ptr_r (pointer skipped a disabled output) opens a fresh burst.
    assign burst_eff_s  = ((state_r == ST_IDLE) && (sel_s != ptr_r)) ? 8'd0 : burst_cnt_r;
    assign burst_last_s = (burst_eff_s == 8'(PKTS_PER_OUTPUT - 1));
    assign next_ptr_s   = (dest_s == DEST_BITS'(N - 1)) ? '0 : dest_s + DEST_BITS'(1);

    // Packet lock state machine plus round-robin pointer and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            dest_r      <= '0;
            burst_cnt_r <= 8'd0;
        end else if (hs_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!axis_i_tlast) begin
                        state_r <= ST_PKT;
                        dest_r  <= sel_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PKT: begin
                    if (axis_i_tlast) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PKT;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            if (axis_i_tlast) begin
                if (burst_last_s) begin
                    ptr_r       <= next_ptr_s;
                    burst_cnt_r <= 8'd0;
                end else begin
                    ptr_r       <= dest_s;
                    burst_cnt_r <= burst_eff_s + 8'd1;
                end
            end else begin
                burst_cnt_r <= burst_eff_s;
            end
        end else begin
            state_r <= state_r;
        end
    end

`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
    logic [31:0] pkt_cnt_r [N];

    // Per-output completed-packet counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!sresetn) begin
                pkt_cnt_r[i] <= 32'd0;
            end else if (hs_s && axis_i_tlast && (dest_s == DEST_BITS'(i))) begin
                pkt_cnt_r[i] <= pkt_cnt_r[i] + 32'd1;
            end else begin
                pkt_cnt_r[i] <= pkt_cnt_r[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt
        assign pkt_count[g*32 +: 32] = pkt_cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_axis_packet_distributor.sv
// Self-checking bench for axis_packet_distributor: three instances (N=3/P=1, N=3/P=2, N=4/P=1) and a beat scoreboard.
`timescale 1ns/1ps
module tb_axis_packet_distributor;

    typedef struct packed {
        logic [1:0] dest;
        logic [7:0] data;
        logic       last;
        logic       busy;
    } beat_t;

    typedef struct {
        int         dut;
        logic [3:0] en;
        int         beats;
        logic [1:0] dest;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sresetn;
    logic       tvalid, tlast;
    logic [7:0] tdata;
    logic [0:0] tkeep, tuser;

    logic [2:0]  en_a, en_b, rdy_a, rdy_b;
    logic [3:0]  en_c, rdy_c;
    logic        irdy_a, irdy_b, irdy_c;
    logic [2:0]  ov_a, ol_a, ok_a, ou_a, ov_b, ol_b, ok_b, ou_b;
    logic [3:0]  ov_c, ol_c, ok_c, ou_c;
    logic [23:0] od_a, od_b;
    logic [31:0] od_c;
    logic [1:0]  cur_a, cur_b, cur_c;
    logic        busy_a, busy_b, busy_c;
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
    logic [95:0]  pc_a, pc_b;
    logic [127:0] pc_c;
`endif

    axis_packet_distributor #(.NUM_SLAVE_STREAMS(3), .PKTS_PER_OUTPUT(1)) u_dut_a (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tvalid(tvalid), .axis_i_tready(irdy_a), .axis_i_tlast(tlast),
        .axis_i_tdata(tdata), .axis_i_tkeep(tkeep), .axis_i_tuser(tuser),
        .axis_o_tvalid(ov_a), .axis_o_tready(rdy_a), .axis_o_tlast(ol_a),
        .axis_o_tdata(od_a), .axis_o_tkeep(ok_a), .axis_o_tuser(ou_a),
        .en_mask(en_a), .cur_dest(cur_a), .busy(busy_a)
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
        , .pkt_count(pc_a)
`endif
    );

    axis_packet_distributor #(.NUM_SLAVE_STREAMS(3), .PKTS_PER_OUTPUT(2)) u_dut_b (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tvalid(tvalid), .axis_i_tready(irdy_b), .axis_i_tlast(tlast),
        .axis_i_tdata(tdata), .axis_i_tkeep(tkeep), .axis_i_tuser(tuser),
        .axis_o_tvalid(ov_b), .axis_o_tready(rdy_b), .axis_o_tlast(ol_b),
        .axis_o_tdata(od_b), .axis_o_tkeep(ok_b), .axis_o_tuser(ou_b),
        .en_mask(en_b), .cur_dest(cur_b), .busy(busy_b)
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
        , .pkt_count(pc_b)
`endif
    );

    axis_packet_distributor #(.NUM_SLAVE_STREAMS(4), .PKTS_PER_OUTPUT(1)) u_dut_c (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tvalid(tvalid), .axis_i_tready(irdy_c), .axis_i_tlast(tlast),
        .axis_i_tdata(tdata), .axis_i_tkeep(tkeep), .axis_i_tuser(tuser),
        .axis_o_tvalid(ov_c), .axis_o_tready(rdy_c), .axis_o_tlast(ol_c),
        .axis_o_tdata(od_c), .axis_o_tkeep(ok_c), .axis_o_tuser(ou_c),
        .en_mask(en_c), .cur_dest(cur_c), .busy(busy_c)
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
        , .pkt_count(pc_c)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          dut_sel;
    beat_t       sb_q[$];

    logic        mon_irdy, mon_busy;
    logic [1:0]  mon_cur;
    logic [3:0]  mon_ov, mon_ol;
    logic [31:0] mon_od;

    always_comb begin
        case (dut_sel)
            0: begin
                mon_irdy = irdy_a; mon_busy = busy_a; mon_cur = cur_a;
                mon_ov = {1'b0, ov_a}; mon_ol = {1'b0, ol_a}; mon_od = {8'h00, od_a};
            end
            1: begin
                mon_irdy = irdy_b; mon_busy = busy_b; mon_cur = cur_b;
                mon_ov = {1'b0, ov_b}; mon_ol = {1'b0, ol_b}; mon_od = {8'h00, od_b};
            end
            default: begin
                mon_irdy = irdy_c; mon_busy = busy_c; mon_cur = cur_c;
                mon_ov = ov_c; mon_ol = ol_c; mon_od = od_c;
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        beat_t e;
        if (sresetn && tvalid && mon_irdy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("dest_valid", 32'(mon_ov), 32'(4'b0001 << e.dest));
                check("data", 32'(mon_od[e.dest*8 +: 8]), 32'(e.data));
                check("last", 32'(mon_ol[e.dest]), 32'(e.last));
                check("busy", 32'(mon_busy), 32'(e.busy));
                check("cur_dest", 32'(mon_cur), 32'(e.dest));
            end
        end
    end

    task automatic apply_en(input int dut, input logic [3:0] en);
        en_a = (dut == 0) ? en[2:0] : 3'b000;
        en_b = (dut == 1) ? en[2:0] : 3'b000;
        en_c = (dut == 2) ? en : 4'b0000;
    endtask

    task automatic send_beat(input logic [1:0] d, input logic last, input logic bsy, output int stalls);
        beat_t e;
        tdata  = 8'($urandom);
        tlast  = last;
        tvalid = 1'b1;
        e.dest = d; e.data = tdata; e.last = last; e.busy = bsy;
        sb_q.push_back(e);
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mon_irdy) break;
            stalls++;
        end
        if (stalls >= 20) begin
            check("handshake_timeout", 32'd1, 32'd0);
            void'(sb_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [1:0] d, input int beats, output int stalls);
        int s;
        stalls = 0;
        for (int b = 0; b < beats; b++) begin
            send_beat(d, (b == beats - 1), (b != 0), s);
            stalls += s;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[13];
        int   st;
        vt[0]  = '{0, 4'b0111, 4, 2'd0};
        vt[1]  = '{0, 4'b0111, 4, 2'd1};
        vt[2]  = '{0, 4'b0111, 4, 2'd2};
        vt[3]  = '{0, 4'b0111, 4, 2'd0};
        vt[4]  = '{0, 4'b0111, 4, 2'd1};
        vt[5]  = '{0, 4'b0111, 4, 2'd2};
        vt[6]  = '{1, 4'b0111, 1, 2'd0};
        vt[7]  = '{1, 4'b0111, 1, 2'd0};
        vt[8]  = '{1, 4'b0111, 1, 2'd1};
        vt[9]  = '{1, 4'b0111, 1, 2'd1};
        vt[10] = '{2, 4'b1010, 2, 2'd1};
        vt[11] = '{2, 4'b1010, 2, 2'd3};
        vt[12] = '{2, 4'b1010, 2, 2'd1};

        sresetn = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = 8'h00;
        tkeep = 1'b1; tuser = 1'b0; dut_sel = 0;
        apply_en(0, 4'b0000);
        rdy_a = 3'b111; rdy_b = 3'b111; rdy_c = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'({busy_a, busy_b, busy_c}), 32'd0);
        check("reset_cur", 32'({cur_a, cur_b, cur_c}), 32'd0);
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
        check("reset_pkt_count_a", 32'(pc_a != 96'd0), 32'd0);
`endif
        @(posedge clk); #1;
        sresetn = 1'b1;
        @(posedge clk); #1;

        // Table: round robin, bursts of two, and skipping disabled outputs.
        for (int i = 0; i < 13; i++) begin
            dut_sel = vt[i].dut;
            apply_en(vt[i].dut, vt[i].en);
            send_pkt(vt[i].dest, vt[i].beats, st);
            if (vt[i].dut == 0) check("one_beat_per_cycle", 32'(st), 32'd0);
        end
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
        check("pkt_count_a_any", 32'(pc_a == {32'd2, 32'd2, 32'd2}), 32'd1);
`endif

        // Mask change mid-packet is ignored; the next packet follows the new mask.
        dut_sel = 2;
        apply_en(2, 4'b0011);
        send_beat(2'd0, 1'b0, 1'b0, st);
        en_c = 4'b0010;
        send_beat(2'd0, 1'b0, 1'b1, st);
        send_beat(2'd0, 1'b1, 1'b1, st);
        tvalid = 1'b0; tlast = 1'b0;
        send_pkt(2'd1, 1, st);

        // No enabled output: input stalls; enabling output 2 accepts in the same cycle.
        dut_sel = 0;
        apply_en(0, 4'b0000);
        tvalid = 1'b1; tlast = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("none_enabled_tready", 32'(irdy_a), 32'd0);
            check("none_enabled_tvalid", 32'(ov_a), 32'd0);
        end
        @(posedge clk); #1;
        en_a = 3'b100;
        send_beat(2'd2, 1'b1, 1'b0, st);
        check("enable_same_cycle", 32'(st), 32'd0);
        tvalid = 1'b0; tlast = 1'b0;

        // Downstream stall then reset mid-packet.
        apply_en(0, 4'b0111);
        send_beat(2'd0, 1'b0, 1'b0, st);
        send_beat(2'd0, 1'b0, 1'b1, st);
        rdy_a = 3'b110;
        tvalid = 1'b1; tlast = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_tready", 32'(irdy_a), 32'd0);
            check("stall_tvalid", 32'(ov_a), 32'd1);
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        sresetn = 1'b0;
        @(posedge clk); #1;
        sresetn = 1'b1;
        rdy_a = 3'b111;
        @(negedge clk);
        check("post_reset_busy", 32'(busy_a), 32'd0);
        check("post_reset_cur", 32'(cur_a), 32'd0);
`ifdef AXIS_PACKET_DISTRIBUTOR_PKT_COUNT_EN
        check("post_reset_pkt_count", 32'(pc_a != 96'd0), 32'd0);
`endif
        @(posedge clk); #1;
        send_pkt(2'd0, 2, st);

        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
